uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 35 +++
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Host-write / transmitter-launch signal bundle for uart_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8
) ();
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               wr_en;
  logic [7:0]         wr_data;
  logic               flush;
  logic               full;
  logic               empty;
  logic [c_cnt_w-1:0] count;
  logic               overflow;
  logic               launch_err;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;

  // master is the environment: host writer plus the transmitter core's busy flag
  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, count, overflow, launch_err, tx_data, tx_start
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, count, overflow, launch_err, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO that launches queued bytes into a UART transmitter core.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH   = 8,   // power of two, 2..16
  parameter int TIMEOUT = 16   // >= 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_tx_fifo_if.slave bus
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_tw-1:0] c_to_last = c_tw'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic [c_tw-1:0] r_to_cnt;
  logic [c_tw-1:0] w_to_cnt_nxt;
  logic [7:0]      r_tx_data;
  logic            r_overflow;
  logic            r_launch_err;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_pop;
  logic            w_timeout;

  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  // A same-cycle pop never makes room: acceptance looks only at the registered count
  assign w_wr_acc = bus.wr_en & ~bus.flush & ~w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
    end
  end

  // r_to_cnt counts cycles since LAUNCH, so a timeout lands TIMEOUT cycles after it
  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = r_to_cnt;
    w_pop        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_to_cnt_nxt = c_tw'(1);
        w_state_nxt  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_to_cnt == c_to_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_tx_data    <= 8'h00;
      r_overflow   <= 1'b0;
      r_launch_err <= 1'b0;
    end else begin
      r_overflow   <= bus.wr_en & ~bus.flush & w_full;
      r_launch_err <= w_timeout;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
      // flush still lets an IDLE pop load tx_data; the queue simply ends empty
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_wr_acc, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.launch_err = r_launch_err;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_start   = (r_state == S_LAUNCH);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed, table-driven bench for uart_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int NVEC    = 19;

  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       busy;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       overflow;
    logic       launch_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs [NVEC];

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},      32'(bus.count),      32'd0);
    check({tag, "_empty"},      32'(bus.empty),      32'd1);
    check({tag, "_full"},       32'(bus.full),       32'd0);
    check({tag, "_tx_start"},   32'(bus.tx_start),   32'd0);
    check({tag, "_tx_data"},    32'(bus.tx_data),    32'h00);
    check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
    check({tag, "_launch_err"}, 32'(bus.launch_err), 32'd0);
  endtask

  // From the LAUNCH cycle: busy seen in WAIT_BUSY, dropped in WAIT_DONE, ends in IDLE
  task automatic serve();
    bus.tx_busy = 1'b1;
    step();
    step();
    bus.tx_busy = 1'b0;
    step();
  endtask

  task automatic wait_start(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (bus.tx_start) seen = 1'b1;
    end
    check("tx_start_within_bound", 32'(seen), 32'd1);
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic bsy,
                              input logic [3:0] cnt, input logic emp, input logic ts,
                              input logic [7:0] td);
    vec_t v;
    v.wr_en      = we;
    v.wr_data    = wd;
    v.flush      = 1'b0;
    v.busy       = bsy;
    v.count      = cnt;
    v.empty      = emp;
    v.full       = 1'b0;
    v.tx_start   = ts;
    v.tx_data    = td;
    v.overflow   = 1'b0;
    v.launch_err = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int err_cnt, err_at, start2_at, starts;
  logic [7:0] data2;

  initial begin
    // Single-byte launch, then a second byte left in flight with busy held high
    vecs[0] = mk(1'b1, 8'hA5, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00);
    vecs[1] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 8'hA5);
    vecs[2] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 8'hA5);
    vecs[3] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 8'hA5);
    for (int i = 4; i < 14; i++) vecs[i] = mk(1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 8'hA5);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 8'hA5);
    vecs[15] = mk(1'b1, 8'h3C, 1'b0, 4'd1, 1'b0, 1'b0, 8'hA5);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 8'h3C);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 8'h3C);
    vecs[18] = mk(1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 8'h3C);

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.tx_busy = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.flush   = vecs[i].flush;
      bus.tx_busy = vecs[i].busy;
      step();
      check($sformatf("vec%0d_count", i),      32'(bus.count),      32'(vecs[i].count));
      check($sformatf("vec%0d_empty", i),      32'(bus.empty),      32'(vecs[i].empty));
      check($sformatf("vec%0d_full", i),       32'(bus.full),       32'(vecs[i].full));
      check($sformatf("vec%0d_tx_start", i),   32'(bus.tx_start),   32'(vecs[i].tx_start));
      check($sformatf("vec%0d_tx_data", i),    32'(bus.tx_data),    32'(vecs[i].tx_data));
      check($sformatf("vec%0d_overflow", i),   32'(bus.overflow),   32'(vecs[i].overflow));
      check($sformatf("vec%0d_launch_err", i), 32'(bus.launch_err), 32'(vecs[i].launch_err));
    end
    bus.wr_en = 1'b0;

    // Fill while 8'h3C is still in flight: 8 bytes fit, the 9th overflows
    for (int n = 1; n <= 9; n++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(n);
      step();
      check($sformatf("fill%0d_count", n),    32'(bus.count),    32'((n > 8) ? 8 : n));
      check($sformatf("fill%0d_full", n),     32'(bus.full),     32'((n >= 8) ? 1 : 0));
      check($sformatf("fill%0d_overflow", n), 32'(bus.overflow), 32'((n == 9) ? 1 : 0));
    end
    bus.wr_en = 1'b0;
    step();
    check("fill_overflow_once", 32'(bus.overflow), 32'd0);

    // Release busy; in IDLE a write while full is rejected even though a pop happens
    bus.tx_busy = 1'b0;
    step();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    step();
    bus.wr_en = 1'b0;
    check("pop_full_count",    32'(bus.count),    32'd7);
    check("pop_full_overflow", 32'(bus.overflow), 32'd1);
    check("pop_full_tx_start", 32'(bus.tx_start), 32'd1);
    check("drain1_tx_data",    32'(bus.tx_data),  32'h01);
    serve();
    for (int k = 2; k <= 8; k++) begin
      wait_start(12);
      check($sformatf("drain%0d_tx_data", k), 32'(bus.tx_data), 32'(k));
      serve();
    end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.tx_start) starts++;
    end
    check("drain_no_extra_start", 32'(starts), 32'd0);
    check("drain_empty",          32'(bus.empty), 32'd1);

    // Launch timeout: transmitter never goes busy
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    step();
    bus.wr_data = 8'h66;
    step();
    bus.wr_en = 1'b0;
    check("to_launch_tx_start", 32'(bus.tx_start), 32'd1);
    check("to_launch_tx_data",  32'(bus.tx_data),  32'h55);
    err_cnt = 0; err_at = -1; start2_at = -1; data2 = 8'h00;
    for (int k = 1; k <= TIMEOUT + 3; k++) begin
      step();
      if (bus.launch_err) begin
        err_cnt++;
        err_at = k;
      end
      if (bus.tx_start && start2_at < 0) begin
        start2_at = k;
        data2     = bus.tx_data;
      end
    end
    check("to_err_pulses",  32'(err_cnt),   32'd1);
    check("to_err_cycle",   32'(err_at),    32'(TIMEOUT));
    check("to_next_launch", 32'(start2_at), 32'(TIMEOUT + 1));
    check("to_next_data",   32'(data2),     32'h66);
    bus.tx_busy = 1'b1;
    step();
    bus.tx_busy = 1'b0;
    step();

    // Flush together with a write while one byte is in flight
    bus.wr_en = 1'b1; bus.wr_data = 8'h11;
    step();
    bus.wr_data = 8'h22;
    step();
    check("fl_launch_tx_start", 32'(bus.tx_start), 32'd1);
    check("fl_launch_tx_data",  32'(bus.tx_data),  32'h11);
    bus.wr_data = 8'h33;
    step();
    bus.wr_data = 8'h44;
    bus.tx_busy = 1'b1;
    step();
    check("fl_queued_count", 32'(bus.count), 32'd3);
    bus.wr_data = 8'h55;
    bus.flush   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    check("fl_count", 32'(bus.count), 32'd0);
    check("fl_empty", 32'(bus.empty), 32'd1);
    step();
    check("fl_overflow", 32'(bus.overflow), 32'd0);
    bus.tx_busy = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.tx_start) starts++;
    end
    check("fl_no_more_start", 32'(starts),       32'd0);
    check("fl_tx_data_held",  32'(bus.tx_data),  32'h11);
    check("fl_still_empty",   32'(bus.empty),    32'd1);

    // Reset in WAIT_DONE with three bytes queued
    bus.wr_en = 1'b1; bus.wr_data = 8'h71;
    step();
    bus.wr_en = 1'b0;
    step();
    check("rs_launch_tx_start", 32'(bus.tx_start), 32'd1);
    bus.tx_busy = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h72 + i);
      step();
    end
    bus.wr_en = 1'b0;
    check("rs_queued_count", 32'(bus.count), 32'd3);
    rst = 1'b1;
    step();
    check_reset_values("midrst");
    rst = 1'b0;
    bus.tx_busy = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.tx_start) starts++;
    end
    check("rs_no_start", 32'(starts),    32'd0);
    check("rs_empty",    32'(bus.empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
